// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared FSM type, constants and one-hot decode helper for the LED scan decoder.
package led_matrix_pkg;
   typedef enum logic [1:0] {WAIT_ROW, SETTLE, HOLD} scan_state_t;
   localparam int N_DEFAULT   = 5;
   localparam int SYNC_STAGES = 2;
   typedef struct packed {
      logic       valid;
      logic [7:0] idx;
   } onehot_t;
   function automatic onehot_t onehot_index(input logic [31:0] v);
      onehot_t r;
      int      hits;
      r    = '0;
      hits = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            hits++;
            r.idx = 8'(i);
         end
      end
      r.valid = (hits == 1);
      return r;
   endfunction
endpackage

// File: rtl/scan_settle_filter.sv
// scan_settle_filter: synchronizes the scan bus and flags it stable after SETTLE_CYCLES unchanged samples.
module scan_settle_filter
   import led_matrix_pkg::*;
#(
   parameter int WIDTH         = 10,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             stable
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev;
   logic [CW-1:0]    cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev <= '0;
         cnt  <= '0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev <= dout;
         cnt  <= (dout != prev) ? '0 : (cnt == CW'(SETTLE_CYCLES)) ? cnt : cnt + CW'(1);
      end
   end
   assign dout   = sync_q[SYNC_STAGES-1];
   assign stable = cnt == CW'(SETTLE_CYCLES);
endmodule

// File: rtl/led_matrix_scan_decoder.sv
// led_matrix_scan_decoder: rebuilds N x N frames from a row/col LED scan bus with valid/ready handoff.
// Define LED_SCAN_ORDER_CHECK_EN to enforce ascending row order and report violations on order_err.
module led_matrix_scan_decoder
   import led_matrix_pkg::*;
#(
   parameter int N              = N_DEFAULT,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter bit COL_ACTIVE_LOW = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   rows,
   input  logic [N-1:0]   cols,
   output logic [N*N-1:0] frame,
   output logic           frame_valid,
   input  logic           frame_ready,
   output logic [7:0]     overrun_count,
   output logic [N-1:0]   row_seen
`ifdef LED_SCAN_ORDER_CHECK_EN
   ,
   output logic           order_err
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   scan_state_t    state, state_n;
   logic [2*N-1:0] bus_s;
   logic [N-1:0]   rows_s, cols_s, pix, rows_hold;
   logic           stable, capture, cap_d, timeout, in_order;
   logic [N*N-1:0] shadow;
   logic [TW-1:0]  to_cnt;
   onehot_t        oh;
   scan_settle_filter #(.WIDTH(2*N), .SETTLE_CYCLES(SETTLE_CYCLES)) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    ({rows, cols}),
      .dout   (bus_s),
      .stable (stable)
   );
   assign {rows_s, cols_s} = bus_s;
   assign pix     = cols_s ^ {N{COL_ACTIVE_LOW}};
   assign oh      = onehot_index(32'(rows_s));
   assign timeout = to_cnt == TW'(TIMEOUT_CYCLES);
`ifdef LED_SCAN_ORDER_CHECK_EN
   logic [7:0] exp_row;
   assign in_order = oh.idx == exp_row;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_row   <= '0;
         order_err <= 1'b0;
      end else begin
         order_err <= capture && !in_order;
         if (capture) exp_row <= (oh.idx == 8'(N-1)) ? 8'd0 : oh.idx + 8'd1;
      end
   end
`else
   assign in_order = 1'b1;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_ROW;
      else        state <= state_n;
   end
   // HOLD ignores cols changes so a row is captured only once per dwell
   always_comb begin
      state_n = state;
      capture = 1'b0;
      case (state)
         WAIT_ROW: state_n = oh.valid ? SETTLE : WAIT_ROW;
         SETTLE: begin
            capture = oh.valid && stable;
            state_n = !oh.valid ? WAIT_ROW : stable ? HOLD : SETTLE;
         end
         HOLD:     state_n = (rows_s != rows_hold) ? WAIT_ROW : HOLD;
         default:  state_n = WAIT_ROW;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame         <= '0;
         frame_valid   <= 1'b0;
         overrun_count <= '0;
         row_seen      <= '0;
         shadow        <= '0;
         rows_hold     <= '0;
         to_cnt        <= '0;
         cap_d         <= 1'b0;
      end else begin
         cap_d  <= capture;
         to_cnt <= (row_seen == '0 || timeout) ? '0 : to_cnt + TW'(1);
         if (frame_valid && frame_ready) frame_valid <= 1'b0;
         if (cap_d && &row_seen) begin
            row_seen <= '0;
            if (!frame_valid || frame_ready) begin
               frame       <= shadow;
               frame_valid <= 1'b1;
            end else begin
               shadow        <= '0;
               overrun_count <= overrun_count + {7'd0, overrun_count != 8'hff};
            end
         end
         if (timeout) begin
            row_seen <= '0;
            shadow   <= '0;
         end
         if (capture) begin
            rows_hold <= rows_s;
            to_cnt    <= '0;
            for (int j = 0; j < N; j++) begin
               if (oh.idx == 8'(j)) begin
                  shadow[j*N +: N] <= pix;
                  row_seen[j]      <= 1'b1;
               end else if (!in_order) begin
                  row_seen[j] <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_led_matrix_scan_decoder.sv
// tb_led_matrix_scan_decoder: directed bench for the LED scan decoder (N=5, SETTLE=2, TIMEOUT=16, active-low cols).
module tb_led_matrix_scan_decoder;
   localparam int N = 5;
   localparam logic [24:0] F1 = 25'b00100_01010_10001_01010_00100;
   localparam logic [24:0] F2 = 25'b11000_00011_10000_00001_11111;
   localparam logic [24:0] F3 = 25'b01001_10010_00111_01110_10101;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           frame_ready = 1'b1;
   logic [N-1:0]   rows = '0;
   logic [N-1:0]   cols = '1;
   logic [N-1:0]   row_seen;
   logic [N*N-1:0] frame;
   logic           frame_valid;
   logic [7:0]     overrun_count;
   logic [4:0]     pats [3][5];
   int             vectors = 0;
   int             miscompares = 0;
`ifdef LED_SCAN_ORDER_CHECK_EN
   logic order_err;
   int   oe_count = 0;
   always @(posedge clk) if (order_err) oe_count++;
`endif
   always #5 clk = ~clk;
   led_matrix_scan_decoder #(.N(N), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16), .COL_ACTIVE_LOW(1'b1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rows          (rows),
      .cols          (cols),
      .frame         (frame),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .overrun_count (overrun_count),
      .row_seen      (row_seen)
`ifdef LED_SCAN_ORDER_CHECK_EN
      ,
      .order_err     (order_err)
`endif
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic scan_row(input int j, input logic [4:0] pat);
      rows = 5'(1 << j);
      cols = ~pat;
      repeat (6) tick();
   endtask
   task automatic scan_frame(input int f);
      for (int j = 0; j < 5; j++) scan_row(j, pats[f][j]);
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      vectors++; if (frame !== '0) begin miscompares++; $display("FAIL reset_frame: got %h want 0", frame); end
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
      vectors++; if (overrun_count !== 8'd0) begin miscompares++; $display("FAIL reset_overrun: got %0d want 0", overrun_count); end
      vectors++; if (row_seen !== 5'b0) begin miscompares++; $display("FAIL reset_row_seen: got %b want 0", row_seen); end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask
   task automatic test_single_frame();
      frame_ready = 1'b1;
      for (int j = 0; j < 3; j++) scan_row(j, pats[0][j]);
      vectors++; if (row_seen !== 5'b00111) begin miscompares++; $display("FAIL single_partial_seen: got %b want 00111", row_seen); end
      for (int j = 3; j < 5; j++) scan_row(j, pats[0][j]);
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_early: got %b want 0", frame_valid); end
      vectors++; if (row_seen !== 5'b11111) begin miscompares++; $display("FAIL single_full_seen: got %b want 11111", row_seen); end
      tick();
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", frame_valid); end
      vectors++; if (frame !== F1) begin miscompares++; $display("FAIL single_frame: got %b want %b", frame, F1); end
      vectors++; if (row_seen !== 5'b0) begin miscompares++; $display("FAIL single_seen_clear: got %b want 0", row_seen); end
      tick();
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_drop: got %b want 0", frame_valid); end
      vectors++; if (overrun_count !== 8'd0) begin miscompares++; $display("FAIL single_overrun: got %0d want 0", overrun_count); end
   endtask
   task automatic test_glitch();
      scan_row(0, pats[1][0]);
      scan_row(1, pats[1][1]);
      rows = 5'b00011;
      tick();
      rows = 5'b00000;
      repeat (2) tick();
      vectors++; if (row_seen !== 5'b00011) begin miscompares++; $display("FAIL glitch_multihot: got %b want 00011", row_seen); end
      rows = 5'b00100;
      tick();
      rows = 5'b00000;
      repeat (3) tick();
      vectors++; if (row_seen !== 5'b00011) begin miscompares++; $display("FAIL glitch_short_row: got %b want 00011", row_seen); end
      for (int j = 2; j < 5; j++) scan_row(j, pats[1][j]);
      tick();
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_valid: got %b want 1", frame_valid); end
      vectors++; if (frame !== F2) begin miscompares++; $display("FAIL glitch_frame: got %b want %b", frame, F2); end
      tick();
   endtask
   task automatic test_cols_toggle();
      scan_row(0, pats[2][0]);
      scan_row(1, pats[2][1]);
      scan_row(2, 5'b00111);
      cols = ~5'b11000;
      repeat (4) tick();
      scan_row(3, pats[2][3]);
      scan_row(4, pats[2][4]);
      tick();
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL toggle_valid: got %b want 1", frame_valid); end
      vectors++; if (frame !== F3) begin miscompares++; $display("FAIL toggle_frame: got %b want %b", frame, F3); end
      tick();
   endtask
   task automatic test_backpressure();
      frame_ready = 1'b0;
      scan_frame(0);
      scan_frame(1);
      scan_frame(2);
      tick();
      vectors++; if (overrun_count !== 8'd2) begin miscompares++; $display("FAIL bp_overrun: got %0d want 2", overrun_count); end
      vectors++; if (frame !== F1) begin miscompares++; $display("FAIL bp_frame: got %b want %b", frame, F1); end
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b want 1", frame_valid); end
      vectors++; if (row_seen !== 5'b0) begin miscompares++; $display("FAIL bp_seen: got %b want 0", row_seen); end
      frame_ready = 1'b1;
      tick();
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop: got %b want 0", frame_valid); end
   endtask
   task automatic test_timeout();
      for (int j = 0; j < 3; j++) scan_row(j, pats[2][j]);
      rows = 5'b00000;
      repeat (16) tick();
      vectors++; if (row_seen !== 5'b00111) begin miscompares++; $display("FAIL timeout_early: got %b want 00111", row_seen); end
      tick();
      vectors++; if (row_seen !== 5'b0) begin miscompares++; $display("FAIL timeout_clear: got %b want 0", row_seen); end
      vectors++; if (frame !== F1) begin miscompares++; $display("FAIL timeout_frame_kept: got %b want %b", frame, F1); end
      vectors++; if (overrun_count !== 8'd2) begin miscompares++; $display("FAIL timeout_overrun_kept: got %0d want 2", overrun_count); end
      scan_frame(1);
      tick();
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL timeout_new_valid: got %b want 1", frame_valid); end
      vectors++; if (frame !== F2) begin miscompares++; $display("FAIL timeout_new_frame: got %b want %b", frame, F2); end
      tick();
   endtask
   task automatic test_reset_mid();
      frame_ready = 1'b0;
      scan_frame(0);
      tick();
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid: got %b want 1", frame_valid); end
      for (int j = 0; j < 3; j++) scan_row(j, pats[2][j]);
      rows = 5'b00000;
      #3 rst_n = 1'b0;
      #1;
      vectors++; if (row_seen !== 5'b0) begin miscompares++; $display("FAIL rstmid_seen: got %b want 0", row_seen); end
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", frame_valid); end
      vectors++; if (overrun_count !== 8'd0) begin miscompares++; $display("FAIL rstmid_overrun: got %0d want 0", overrun_count); end
      tick();
      rst_n = 1'b1;
      frame_ready = 1'b1;
      repeat (2) tick();
      scan_frame(2);
      tick();
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_after_valid: got %b want 1", frame_valid); end
      vectors++; if (frame !== F3) begin miscompares++; $display("FAIL rstmid_after_frame: got %b want %b", frame, F3); end
      tick();
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_after_drop: got %b want 0", frame_valid); end
   endtask
`ifdef LED_SCAN_ORDER_CHECK_EN
   task automatic test_order_check();
      int oe_before;
      rows = 5'b00000;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      oe_before = oe_count;
      scan_row(0, pats[0][0]);
      scan_row(1, pats[0][1]);
      scan_row(3, pats[0][3]);
      rows = 5'b00000;
      repeat (3) tick();
      vectors++; if (oe_count - oe_before !== 1) begin miscompares++; $display("FAIL order_err_pulses: got %0d want 1", oe_count - oe_before); end
      vectors++; if (row_seen !== 5'b01000) begin miscompares++; $display("FAIL order_seen: got %b want 01000", row_seen); end
   endtask
`endif
   initial begin
      pats[0] = '{5'b00100, 5'b01010, 5'b10001, 5'b01010, 5'b00100};
      pats[1] = '{5'b11111, 5'b00001, 5'b10000, 5'b00011, 5'b11000};
      pats[2] = '{5'b10101, 5'b01110, 5'b00111, 5'b10010, 5'b01001};
      test_reset();
      test_single_frame();
      test_glitch();
      test_cols_toggle();
      test_backpressure();
      test_timeout();
      test_reset_mid();
`ifdef LED_SCAN_ORDER_CHECK_EN
      test_order_check();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
